// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module bcd_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_tick,
  output logic                    bcd_err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic [4*NUM_DIGITS-1:0] display_reg;
  logic                    wrapped_reg;

  logic                  wrap_slot;
  logic                  wrap_frame;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [NUM_DIGITS-1:0] pend_ok;
  logic [NUM_DIGITS-1:0] disp_show;

  assign wrap_slot  = (cnt_reg == CNT_MAX);
  assign wrap_frame = wrap_slot && (idx_reg == IDX_MAX);
  assign cur_nib    = display_reg[{idx_reg, 2'b00} +: 4];
  assign sel_onehot = NUM_DIGITS'(1) << idx_reg;

  // Per-digit flags: pending validity decides whether a swap clears bcd_err,
  // disp_show decides whether a displayed digit may light its enable.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] pend_nib;
      logic [3:0] disp_nib;
      assign pend_nib     = pending_reg[4*gi +: 4];
      assign disp_nib     = display_reg[4*gi +: 4];
      assign pend_ok[gi]  = (pend_nib <= 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign disp_show[gi] = (disp_nib <= 4'd9);
      end else if (gi == NUM_DIGITS - 1) begin : g_msd
        assign disp_show[gi] = (disp_nib <= 4'd9) && (disp_nib != 4'd0);
      end else begin : g_mid
        logic upper_zero;
        assign upper_zero    = ~|display_reg[4*NUM_DIGITS-1 -: 4*(NUM_DIGITS-1-gi)];
        assign disp_show[gi] = (disp_nib <= 4'd9) && !((disp_nib == 4'd0) && upper_zero);
      end
`else
      assign disp_show[gi] = (disp_nib <= 4'd9);
`endif
    end
  endgenerate

  // Outputs are registered from the pre-edge slot state, so every output
  // slot trails the counter by one cycle and bcd_out changes during the blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      idx_reg     <= '0;
      pending_reg <= '0;
      display_reg <= '0;
      wrapped_reg <= 1'b0;
      bcd_out     <= 4'd0;
      digit_sel_n <= '1;
      frame_tick  <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      cnt_reg <= wrap_slot ? '0 : cnt_reg + 1'b1;
      if (wrap_slot) begin
        idx_reg <= wrap_frame ? '0 : idx_reg + 1'b1;
      end
      if (wrap_frame) begin
        display_reg <= pending_reg;
      end
      if (load) begin
        pending_reg <= digits_in;
      end
      wrapped_reg <= wrap_frame;
      frame_tick  <= wrapped_reg;
      bcd_out     <= cur_nib;
      digit_sel_n <= ((cnt_reg >= BLANK_CNT) && disp_show[idx_reg]) ? ~sel_onehot : '1;
      if (wrap_frame && (&pend_ok)) begin
        bcd_err <= 1'b0;
      end else if (cur_nib > 4'd9) begin
        bcd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Randomized bench for bcd_scan_mux against a cycle-number based reference model.
// Honors LEADING_ZERO_BLANK_EN the same way as the design.
module tb_bcd_scan_mux;

  localparam int N   = 4;
  localparam int SD  = 8;
  localparam int BL  = 2;
  localparam int FRM = N * SD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [3:0]     bcd_out;
  logic [N-1:0]   digit_sel_n;
  logic           frame_tick;
  logic           bcd_err;

  bcd_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .bcd_out(bcd_out), .digit_sel_n(digit_sel_n),
    .frame_tick(frame_tick), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: n = edges since reset released, pending and shown frames.
  int             n_m = 0;
  logic [4*N-1:0] pend_m = '0;
  logic [4*N-1:0] disp_m = '0;
  logic           err_m = 1'b0;
  logic [3:0]     exp_bcd;
  logic [N-1:0]   exp_sel;
  logic           exp_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%h want=%h", tag, n_m, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [4*N-1:0] b, input int i);
    return b[4*i +: 4];
  endfunction

  function automatic bit digit_lit(input logic [4*N-1:0] b, input int i);
    if (nib(b, i) > 4'd9) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && nib(b, i) == 4'd0) begin
      bit above_nz = 1'b0;
      for (int k = i + 1; k < N; k++) if (nib(b, k) != 4'd0) above_nz = 1'b1;
      if (!above_nz) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  function automatic bit all_valid(input logic [4*N-1:0] b);
    for (int k = 0; k < N; k++) if (nib(b, k) > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one edge using the inputs sampled at that edge.
  task automatic model_edge();
    if (rst) begin
      n_m = 0; pend_m = '0; disp_m = '0; err_m = 1'b0;
      exp_bcd = 4'd0; exp_sel = '1; exp_tick = 1'b0;
    end else begin
      int m, pos, dig;
      bit swap;
      n_m++;
      m   = n_m - 1;
      pos = m % SD;
      dig = (m / SD) % N;
      exp_bcd  = nib(disp_m, dig);
      exp_sel  = (pos >= BL && digit_lit(disp_m, dig)) ? ~(N'(1) << dig) : '1;
      exp_tick = (m > 0) && (m % FRM == 0);
      swap = (n_m % FRM == 0);
      if (swap && all_valid(pend_m)) err_m = 1'b0;
      else if (nib(disp_m, dig) > 4'd9) err_m = 1'b1;
      if (swap) disp_m = pend_m;
      if (load) pend_m = digits_in;
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [4*N-1:0] d);
    @(negedge clk);
    rst = r; load = ld; digits_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check("digit_sel_n", 32'(digit_sel_n), 32'(exp_sel));
    check("bcd_out",     32'(bcd_out),     32'(exp_bcd));
    check("frame_tick",  32'(frame_tick),  32'(exp_tick));
    check("bcd_err",     32'(bcd_err),     32'(err_m));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, digits_in);
  endtask

  // Idle until the next step lands on the edge with n % FRM == target.
  task automatic idle_until(input int target);
    for (int i = 0; i < FRM && ((n_m + 1) % FRM) != target; i++) step(1'b0, 1'b0, digits_in);
  endtask

  initial begin
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(BL);
    check("first_enable_blank", 32'(digit_sel_n), 32'({N{1'b1}}));
    idle(1);
    check("first_enable_low", 32'(digit_sel_n), 32'(4'b1110));
    idle(40);
    step(1'b0, 1'b1, 16'h1234);
    idle(70);
    step(1'b0, 1'b1, 16'h5678);
    idle(3);
    step(1'b0, 1'b1, 16'h9012);
    idle_until(0);
    step(1'b0, 1'b1, 16'h1111);
    idle(70);
    step(1'b0, 1'b1, 16'h12A4);
    idle(70);
    step(1'b0, 1'b1, 16'h0007);
    idle(40);
    step(1'b0, 1'b1, 16'h0050);
    idle(70);
    step(1'b0, 1'b1, 16'h0000);
    idle(70);
    step(1'b0, 1'b1, 16'h4321);
    idle_until(2 * SD + 5 + 1);
    step(1'b1, 1'b0, digits_in);
    idle(45);
    for (int i = 0; i < 2500; i++) begin
      logic           r, ld;
      logic [4*N-1:0] d;
      r  = ($urandom_range(0, 599) == 0);
      ld = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 7))
          0:       d[4*k +: 4] = 4'(10 + $urandom_range(0, 5));
          1, 2:    d[4*k +: 4] = 4'd0;
          default: d[4*k +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      step(r, ld, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
- Sits directly upstream of the BCD-to-7-segment decoder.
- Holds a double-buffered set of BCD digits and presents one nibble at a time on bcd_out, which drives the decoder A..D inputs with A as MSB.
- Drives the active-low digit enables, with a dead-time blank between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot (1..SCAN_DIV-1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe; captures digits_in into the pending buffer
- digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (least significant)
- bcd_out  output  4  current digit nibble to the decoder; bit3 = A (MSB), bit0 = D
- digit_sel_n  output  NUM_DIGITS  active-low digit enables; bit i = digit i
- frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0
- bcd_err  output  1  sticky; set when a displayed-buffer digit is > 9

Behaviour:
- All state is updated on the rising edge of clk. Synchronous, active-high reset on rst. All outputs are registered.
- Reset values:
  - bcd_out = 0, digit_sel_n = all 1, frame_tick = 0, bcd_err = 0.
  - Slot counter = 0, digit index = 0.
  - Pending and display buffers = 0.
- Reset asserted mid-scan aborts the scan immediately; the next scan starts at digit 0.
- Slot counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, the digit index increments modulo NUM_DIGITS.
- Blanking:
  - During slot counts 0..BLANK_CYCLES-1, digit_sel_n = all 1.
  - During counts BLANK_CYCLES..SCAN_DIV-1, only bit [index] is low.
  - Each enable is therefore low for exactly SCAN_DIV-BLANK_CYCLES consecutive cycles.
  - Between consecutive digits there are exactly BLANK_CYCLES cycles of all-high.
  - The first enable goes low BLANK_CYCLES+1 edges after rst deasserts.
- bcd_out:
  - Updates to the new digit's nibble on the first cycle of each slot, i.e. during the blank, never while an enable is low.
  - Holds that value for the whole slot.
- Load:
  - load = 1 copies digits_in into the pending buffer at that edge.
  - Back-to-back loads: the last one before the frame boundary wins.
- Frame swap:
  - The pending buffer is copied into the display buffer at the edge where the index wraps NUM_DIGITS-1 -> 0.
  - frame_tick pulses high during the first cycle of the digit-0 slot.
  - Changes therefore appear only on whole frames; no tearing.
  - load coincident with the wrap edge: the swap uses the old pending value; the new value is shown in the following frame.
- Invalid digits:
  - If the display-buffer digit for the current slot is > 9, that slot's enable stays high for the whole slot (digit dark).
  - bcd_out still carries the raw nibble.
  - bcd_err is set and held.
  - bcd_err clears only on rst, or at a frame swap where every digit in the new display buffer is <= 9.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined:
  - Digits from NUM_DIGITS-1 down to 1 that equal 0 and have no nonzero digit above them are suppressed (enable held high for the slot).
  - Digit 0 is always shown, even when 0.
  - Slot timing, bcd_out and frame_tick are unchanged.
- Undefined: every valid digit is displayed, including leading zeros.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4):
- Reset then free-run with buffers 0 -> digit_sel_n cycles 1110, 1101, 1011, 0111. Each pattern is low 6 cycles with 2 cycles of 1111 between. frame_tick pulses every 32 cycles. bcd_out = 0.
- load with digits_in=16'h1234 mid-frame -> current frame unchanged. From the next frame_tick, bcd_out reads 4, 3, 2, 1 for digits 0..3, each value stable while its enable is low.
- load 16'h5678, then load 16'h9012 in the same frame, with a third load 16'h1111 coincident with the wrap edge -> next frame shows 9012; the frame after shows 1111.
- load 16'h12A4 -> after swap, digit 1 slot stays 1111 for 8 cycles and bcd_err = 1. Then load 16'h0007 -> bcd_err clears at the next swap.
- Assert rst for 1 cycle at slot count 5 of digit 2 -> next edge: digit_sel_n = 1111, bcd_out = 0, buffers 0. The scan restarts at digit 0.
- LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 dark; digits 1 (5) and 0 (0) shown. Load 16'h0000 -> only digit 0 is shown.
